// File: rtl/scoreboard_register_file_if.sv
// Register-file bus: three read ports, one writeback port and the decode
// issue port with its scoreboard feedback.
interface scoreboard_register_file_if #(
    parameter int DBITS = 32,
    parameter int ABITS = 4
);
    logic [ABITS-1:0] rd;
    logic [ABITS-1:0] rs1;
    logic [ABITS-1:0] rs2;
    logic [DBITS-1:0] outd;
    logic [DBITS-1:0] out1;
    logic [DBITS-1:0] out2;
    logic             busyd;
    logic             busy1;
    logic             busy2;
    logic             wrtEn;
    logic [ABITS-1:0] wrtReg;
    logic [DBITS-1:0] wrtData;
    logic             issueEn;
    logic [ABITS-1:0] issueReg;
    logic             issueStall;
    logic             pendErr;

    // Pipeline side: drives addresses, writeback and issue requests.
    modport master (
        output rd, rs1, rs2, wrtEn, wrtReg, wrtData, issueEn, issueReg,
        input  outd, out1, out2, busyd, busy1, busy2, issueStall, pendErr
    );

    // Register file side.
    modport slave (
        input  rd, rs1, rs2, wrtEn, wrtReg, wrtData, issueEn, issueReg,
        output outd, out1, out2, busyd, busy1, busy2, issueStall, pendErr
    );
endinterface

// File: rtl/scoreboard_register_file.sv
// Parametrised register file with three combinational read ports, one
// synchronous write port, optional write-to-read bypass, optional
// hardwired-zero r0 and a per-register pending-write scoreboard used by
// decode to stall on RAW/WAW hazards.
module scoreboard_register_file #(
    parameter int DBITS   = 32,
    parameter int ABITS   = 4,
    parameter int PBITS   = 2,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input logic                   clk,
    input logic                   reset,
    scoreboard_register_file_if.slave bus
);
    localparam int             NREGS = 1 << ABITS;
    localparam bit             ZR    = (ZERO_R0 != 0);
    localparam bit             BP    = (BYPASS != 0);
    localparam logic [PBITS-1:0] PMAX = '1;

    logic [DBITS-1:0] regs    [NREGS];
    logic [PBITS-1:0] pending [NREGS];
    logic             pend_err_q;

    logic             wb_acc;
    logic             issue_stall;
    logic             issue_acc;
    logic [ABITS-1:0] raddr [3];
    logic [DBITS-1:0] rdata [3];
    logic             rbusy [3];

    // Accepted writeback / issue after r0 masking and saturation stall.
    // The stall looks only at the current count, so a same-cycle writeback
    // to a saturated register still stalls (conservative).
    always_comb begin
        wb_acc      = bus.wrtEn && !(ZR && (bus.wrtReg == '0));
        issue_stall = bus.issueEn && (pending[bus.issueReg] == PMAX);
        issue_acc   = bus.issueEn && !issue_stall && !(ZR && (bus.issueReg == '0));
    end

    // Read ports: data with optional bypass, busy after this cycle's writeback.
    always_comb begin
        raddr[0] = bus.rd;
        raddr[1] = bus.rs1;
        raddr[2] = bus.rs2;
        for (int p = 0; p < 3; p++) begin
            rdata[p] = regs[raddr[p]];
            rbusy[p] = (pending[raddr[p]] != '0);
            if (BP && bus.wrtEn && (bus.wrtReg == raddr[p])) begin
                rdata[p] = bus.wrtData;
            end
            // A bypassed writeback retires one outstanding write; a count
            // of 0 (underflow) cannot go lower, so it stays not-busy.
            if (BP && wb_acc && (bus.wrtReg == raddr[p]) && (pending[raddr[p]] == PBITS'(1))) begin
                rbusy[p] = 1'b0;
            end
            if (ZR && (raddr[p] == '0)) begin
                rdata[p] = '0;
                rbusy[p] = 1'b0;
            end
        end
    end

    assign bus.outd       = rdata[0];
    assign bus.out1       = rdata[1];
    assign bus.out2       = rdata[2];
    assign bus.busyd      = rbusy[0];
    assign bus.busy1      = rbusy[1];
    assign bus.busy2      = rbusy[2];
    assign bus.issueStall = issue_stall;
    assign bus.pendErr    = pend_err_q;

    // Data array write; a dropped r0 write never reaches the array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wb_acc) begin
            regs[bus.wrtReg] <= bus.wrtData;
        end
    end

    // Pending-write counters: +1 on accepted issue, -1 on writeback,
    // unchanged when both hit the same register; never wraps either way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                pending[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                logic inc;
                logic dec;
                inc = issue_acc && (bus.issueReg == ABITS'(r));
                dec = wb_acc && (bus.wrtReg == ABITS'(r)) && (pending[r] != '0);
                if (inc && !dec) begin
                    pending[r] <= pending[r] + PBITS'(1);
                end else if (dec && !inc) begin
                    pending[r] <= pending[r] - PBITS'(1);
                end
            end
        end
    end

    // Sticky flag for a writeback that had no outstanding issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_err_q <= 1'b0;
        end else if (wb_acc && (pending[bus.wrtReg] == '0)) begin
            pend_err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_scoreboard_register_file.sv
// Bench for scoreboard_register_file: three instances share one stimulus
// stream (A: bypass on, B: bypass off, Z: hardwired-zero r0).
module tb_scoreboard_register_file;
    logic clk;
    logic reset;

    logic        t_we;
    logic [3:0]  t_wr;
    logic [31:0] t_wd;
    logic        t_ie;
    logic [3:0]  t_ir;
    logic [3:0]  t_r1;
    logic [3:0]  t_r2;
    logic [3:0]  t_rd;

    scoreboard_register_file_if #(.DBITS(32), .ABITS(4)) ifa ();
    scoreboard_register_file_if #(.DBITS(32), .ABITS(4)) ifb ();
    scoreboard_register_file_if #(.DBITS(32), .ABITS(4)) ifz ();

    assign ifa.wrtEn = t_we;   assign ifb.wrtEn = t_we;   assign ifz.wrtEn = t_we;
    assign ifa.wrtReg = t_wr;  assign ifb.wrtReg = t_wr;  assign ifz.wrtReg = t_wr;
    assign ifa.wrtData = t_wd; assign ifb.wrtData = t_wd; assign ifz.wrtData = t_wd;
    assign ifa.issueEn = t_ie; assign ifb.issueEn = t_ie; assign ifz.issueEn = t_ie;
    assign ifa.issueReg = t_ir; assign ifb.issueReg = t_ir; assign ifz.issueReg = t_ir;
    assign ifa.rs1 = t_r1;     assign ifb.rs1 = t_r1;     assign ifz.rs1 = t_r1;
    assign ifa.rs2 = t_r2;     assign ifb.rs2 = t_r2;     assign ifz.rs2 = t_r2;
    assign ifa.rd = t_rd;      assign ifb.rd = t_rd;      assign ifz.rd = t_rd;

    scoreboard_register_file #(.DBITS(32), .ABITS(4), .PBITS(2), .ZERO_R0(0), .BYPASS(1))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));
    scoreboard_register_file #(.DBITS(32), .ABITS(4), .PBITS(2), .ZERO_R0(0), .BYPASS(0))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));
    scoreboard_register_file #(.DBITS(32), .ABITS(4), .PBITS(2), .ZERO_R0(1), .BYPASS(1))
        dut_z (.clk(clk), .reset(reset), .bus(ifz));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        A_OUT1, A_OUTD, A_BUSY1, A_BUSY2, A_STALL, A_PERR,
        B_OUT1, B_BUSY1, B_BUSY2, Z_OUT1, Z_BUSY1, Z_STALL
    } sel_t;

    typedef struct {
        string       name;
        sel_t        sel;
        int unsigned exp;
    } exp_t;

    typedef struct {
        int unsigned we, wr, wd, ie, ir, r1, r2, rd;
        int unsigned a_out1, a_outd, a_busy1, a_busy2, a_stall, a_perr;
        int unsigned b_out1, b_busy1, b_busy2;
    } vec_t;

    exp_t exp_q[$];
    int   n_compared = 0;
    int   n_mismatched = 0;

    function automatic int unsigned actual(sel_t s);
        case (s)
            A_OUT1:  return ifa.out1;
            A_OUTD:  return ifa.outd;
            A_BUSY1: return 32'(ifa.busy1);
            A_BUSY2: return 32'(ifa.busy2);
            A_STALL: return 32'(ifa.issueStall);
            A_PERR:  return 32'(ifa.pendErr);
            B_OUT1:  return ifb.out1;
            B_BUSY1: return 32'(ifb.busy1);
            B_BUSY2: return 32'(ifb.busy2);
            Z_OUT1:  return ifz.out1;
            Z_BUSY1: return 32'(ifz.busy1);
            default: return 32'(ifz.issueStall);
        endcase
    endfunction

    task automatic expect_val(string name, sel_t s, int unsigned e);
        exp_t x;
        x.name = name;
        x.sel  = s;
        x.exp  = e;
        exp_q.push_back(x);
    endtask

    task automatic check_q();
        while (exp_q.size() > 0) begin
            exp_t x;
            int unsigned got;
            x   = exp_q.pop_front();
            got = actual(x.sel);
            n_compared++;
            if (got !== x.exp) begin
                n_mismatched++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", x.name, got, x.exp);
            end
        end
    endtask

    // Wait for the falling edge, apply one cycle of stimulus, let it settle.
    task automatic step(int unsigned we, int unsigned wr, int unsigned wd,
                        int unsigned ie, int unsigned ir,
                        int unsigned r1, int unsigned r2, int unsigned rd);
        @(negedge clk);
        t_we = 1'(we);  t_wr = 4'(wr);  t_wd = wd;
        t_ie = 1'(ie);  t_ir = 4'(ir);
        t_r1 = 4'(r1);  t_r2 = 4'(r2);  t_rd = 4'(rd);
        #2;
    endtask

    vec_t tbl [16];

    initial begin
        //           we wr wd            ie ir r1 r2 rd | aout1        aoutd        ab1 ab2 ast ape | bout1        bb1 bb2
        tbl[0]  = '{0, 0, 0,            0, 0, 3, 15, 0,  0,           0,           0,  0,  0,  0,   0,           0,  0};
        tbl[1]  = '{0, 0, 0,            1, 5, 5, 15, 0,  0,           0,           0,  0,  0,  0,   0,           0,  0};
        tbl[2]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0,  0,   0,           1,  1};
        tbl[3]  = '{0, 0, 0,            0, 0, 5, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0,  0,   32'hDEADBEEF, 0, 0};
        tbl[4]  = '{0, 0, 0,            1, 7, 7, 5,  0,  0,           0,           0,  0,  0,  0,   0,           0,  0};
        tbl[5]  = '{0, 0, 0,            1, 7, 7, 5,  0,  0,           0,           1,  0,  0,  0,   0,           1,  0};
        tbl[6]  = '{0, 0, 0,            1, 7, 7, 5,  0,  0,           0,           1,  0,  0,  0,   0,           1,  0};
        tbl[7]  = '{0, 0, 0,            1, 7, 7, 5,  0,  0,           0,           1,  0,  1,  0,   0,           1,  0};
        tbl[8]  = '{1, 7, 32'h77,       0, 0, 7, 7,  7,  32'h77,      32'h77,      1,  1,  0,  0,   0,           1,  1};
        tbl[9]  = '{1, 7, 32'h78,       0, 0, 7, 7,  7,  32'h78,      32'h78,      1,  1,  0,  0,   32'h77,      1,  1};
        tbl[10] = '{1, 7, 32'h79,       0, 0, 7, 7,  7,  32'h79,      32'h79,      0,  0,  0,  0,   32'h78,      1,  1};
        tbl[11] = '{0, 0, 0,            1, 4, 7, 4,  0,  32'h79,      0,           0,  0,  0,  0,   32'h79,      0,  0};
        tbl[12] = '{1, 4, 32'h44,       1, 4, 7, 4,  4,  32'h79,      32'h44,      0,  0,  0,  0,   32'h79,      0,  1};
        tbl[13] = '{0, 0, 0,            0, 0, 7, 4,  4,  32'h79,      32'h44,      0,  1,  0,  0,   32'h79,      0,  1};
        tbl[14] = '{1, 9, 32'h99,       0, 0, 9, 4,  4,  32'h99,      32'h44,      0,  1,  0,  0,   0,           0,  1};
        tbl[15] = '{0, 0, 0,            0, 0, 9, 4,  4,  32'h99,      32'h44,      0,  1,  0,  1,   32'h99,      0,  1};

        reset = 1'b1;
        t_we = 1'b0; t_wr = '0; t_wd = '0; t_ie = 1'b0; t_ir = '0;
        t_r1 = '0;   t_r2 = '0; t_rd = '0;
        #12 reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].ie, tbl[i].ir,
                 tbl[i].r1, tbl[i].r2, tbl[i].rd);
            expect_val($sformatf("v%0d.a_out1", i),  A_OUT1,  tbl[i].a_out1);
            expect_val($sformatf("v%0d.a_outd", i),  A_OUTD,  tbl[i].a_outd);
            expect_val($sformatf("v%0d.a_busy1", i), A_BUSY1, tbl[i].a_busy1);
            expect_val($sformatf("v%0d.a_busy2", i), A_BUSY2, tbl[i].a_busy2);
            expect_val($sformatf("v%0d.a_stall", i), A_STALL, tbl[i].a_stall);
            expect_val($sformatf("v%0d.a_perr", i),  A_PERR,  tbl[i].a_perr);
            expect_val($sformatf("v%0d.b_out1", i),  B_OUT1,  tbl[i].b_out1);
            expect_val($sformatf("v%0d.b_busy1", i), B_BUSY1, tbl[i].b_busy1);
            expect_val($sformatf("v%0d.b_busy2", i), B_BUSY2, tbl[i].b_busy2);
            check_q();
        end

        // Hardwired-zero r0: write and issue to r0 are dropped on Z only.
        step(1, 0, 32'h1234, 1, 0, 0, 4, 0);
        expect_val("zero.z_out1_wr", Z_OUT1, 0);
        expect_val("zero.z_busy1_wr", Z_BUSY1, 0);
        expect_val("zero.z_stall_wr", Z_STALL, 0);
        expect_val("zero.a_out1_wr", A_OUT1, 32'h1234);
        check_q();
        step(0, 0, 0, 0, 0, 0, 4, 0);
        expect_val("zero.z_out1", Z_OUT1, 0);
        expect_val("zero.z_busy1", Z_BUSY1, 0);
        expect_val("zero.a_out1", A_OUT1, 32'h1234);
        expect_val("zero.a_busy1", A_BUSY1, 1);
        expect_val("zero.b_out1", B_OUT1, 32'h1234);
        check_q();

        // Saturated r7 with a same-cycle writeback still stalls the issue.
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 7, 7, 4, 0);
        step(1, 7, 32'h7A, 1, 7, 7, 4, 0);
        expect_val("sat.stall_with_wb", A_STALL, 1);
        expect_val("sat.busy1_with_wb", A_BUSY1, 1);
        check_q();
        step(0, 0, 0, 1, 7, 7, 4, 0);
        expect_val("sat.stall_after_wb", A_STALL, 0);
        expect_val("sat.busy1_after_wb", A_BUSY1, 1);
        check_q();

        // Asynchronous reset between edges with r7 saturated and r4 busy.
        step(0, 0, 0, 1, 7, 7, 4, 4);
        expect_val("rst.stall_before", A_STALL, 1);
        check_q();
        reset = 1'b1;
        #1;
        expect_val("rst.a_out1", A_OUT1, 0);
        expect_val("rst.a_outd", A_OUTD, 0);
        expect_val("rst.a_busy1", A_BUSY1, 0);
        expect_val("rst.a_busy2", A_BUSY2, 0);
        expect_val("rst.a_stall", A_STALL, 0);
        expect_val("rst.a_perr", A_PERR, 0);
        check_q();
        // Edge while reset is held must not write.
        step(1, 3, 32'h33, 0, 0, 3, 4, 4);
        step(0, 0, 0, 0, 0, 3, 4, 4);
        reset = 1'b0;
        #1;
        expect_val("rst.held_edge_a", A_OUT1, 0);
        expect_val("rst.held_edge_b", B_OUT1, 0);
        expect_val("rst.held_perr", A_PERR, 0);
        check_q();
        // Behaves as from power-up: unissued writeback sets pendErr again.
        step(1, 3, 32'h33, 0, 0, 3, 4, 4);
        step(0, 0, 0, 0, 0, 3, 4, 4);
        expect_val("post.a_out1", A_OUT1, 32'h33);
        expect_val("post.b_out1", B_OUT1, 32'h33);
        expect_val("post.a_perr", A_PERR, 1);
        check_q();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
